// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes and controller states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Only the four movement modes make a multi-step burst meaningful.
  function automatic logic is_shift(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One-step next-state function of the shift register; shared by single-step and burst paths.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
      MODE_LOAD: q_nxt = d;
      MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
      default:   q_nxt = q;  // HOLD and the unused codes 6/7
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation in IDLE and a counted burst mode.
//   state | meaning
//   IDLE  | apply Mode every edge, or latch Mode/Count when Start is high
//   RUN   | apply latched mode once per edge, counting down the remaining steps
//   FIN   | one-cycle Done pulse, Q held, then back to IDLE
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             Sin_L,
  input  logic             Sin_R,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             Sout_L,
  output logic             Sout_R,
  output logic             Busy,
  output logic             Done
);

  state_e             state, state_nxt;
  logic [2:0]         mode_l, mode_l_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   q_r, q_nxt;
  logic [2:0]         step_mode;
  logic [WIDTH-1:0]   step_q;

  assign step_mode = (state == ST_RUN) ? mode_l : Mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode  (step_mode),
    .q     (q_r),
    .d     (D),
    .sin_l (Sin_L),
    .sin_r (Sin_R),
    .q_nxt (step_q)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= ST_IDLE;
      mode_l <= MODE_HOLD;
      cnt    <= '0;
      q_r    <= '0;
    end else begin
      state  <= state_nxt;
      mode_l <= mode_l_nxt;
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_l_nxt = mode_l;
    cnt_nxt    = cnt;
    q_nxt      = q_r;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          mode_l_nxt = Mode;
          cnt_nxt    = Count;
          state_nxt  = ((Count != '0) && is_shift(Mode)) ? ST_RUN : ST_FIN;
        end else begin
          q_nxt = step_q;
        end
      end
      ST_RUN: begin
        q_nxt   = step_q;
        cnt_nxt = cnt - CNT_W'(1);
        // Terminal count is 1, so the counter never decrements through zero.
        if (cnt == CNT_W'(1)) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Q      = q_r;
  assign Sout_L = q_r[WIDTH-1];
  assign Sout_R = q_r[0];
  assign Busy   = (state != ST_IDLE);
  assign Done   = (state == ST_FIN);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus queues the post-edge expectation, a monitor pops and compares.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LOAD = 3'd3, ROTL = 3'd4, ROTR = 3'd5;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] Mode = HOLD;
  logic [3:0] D = 4'b0000;
  logic       Sin_L = 1'b0;
  logic       Sin_R = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Count = 4'd0;
  logic [3:0] Q;
  logic       Sout_L, Sout_R, Busy, Done;

  univ_shift_reg #(.WIDTH(4), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Mode(Mode), .D(D), .Sin_L(Sin_L), .Sin_R(Sin_R),
    .Start(Start), .Count(Count), .Q(Q), .Sout_L(Sout_L), .Sout_R(Sout_R),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  logic [3:0] exp_q[$];
  logic       exp_b[$];
  logic       exp_d[$];
  string      exp_n[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [3:0] eq;
    logic eb, ed;
    string nm;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        eq = exp_q.pop_front();
        eb = exp_b.pop_front();
        ed = exp_d.pop_front();
        nm = exp_n.pop_front();
        check({nm, " Q"}, Q, eq);
        check({nm, " Busy"}, {3'b0, Busy}, {3'b0, eb});
        check({nm, " Done"}, {3'b0, Done}, {3'b0, ed});
        check({nm, " Sout_L"}, {3'b0, Sout_L}, {3'b0, eq[3]});
        check({nm, " Sout_R"}, {3'b0, Sout_R}, {3'b0, eq[0]});
      end
    end
  end

  task automatic drive(input logic [2:0] m, input logic [3:0] dd, input logic sl, input logic sr,
                       input logic st, input logic [3:0] c,
                       input logic [3:0] eq, input logic eb, input logic ed, input string nm);
    Mode = m; D = dd; Sin_L = sl; Sin_R = sr; Start = st; Count = c;
    exp_q.push_back(eq);
    exp_b.push_back(eb);
    exp_d.push_back(ed);
    exp_n.push_back(nm);
  endtask

  task automatic step(input logic [2:0] m, input logic [3:0] dd, input logic sl, input logic sr,
                      input logic st, input logic [3:0] c,
                      input logic [3:0] eq, input logic eb, input logic ed, input string nm);
    @(negedge Clk);
    drive(m, dd, sl, sr, st, c, eq, eb, ed, nm);
  endtask

  logic [3:0] rotl_pat [4];

  initial begin : stim
    rotl_pat[0] = 4'b0001; rotl_pat[1] = 4'b0010; rotl_pat[2] = 4'b0100; rotl_pat[3] = 4'b1000;

    #2;
    check("reset Q", Q, 4'b0000);
    check("reset Busy", {3'b0, Busy}, 4'b0000);
    check("reset Done", {3'b0, Done}, 4'b0000);

    // First edge after release already performs IDLE work
    @(negedge Clk); Rst_n = 1'b1;
    drive(LOAD, 4'b1011, 0, 0, 0, 0, 4'b1011, 0, 0, "load");
    step(SHL,  4'b0000, 1, 0, 0, 0, 4'b0111, 0, 0, "shl");

    step(LOAD, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "clear");
    step(SHR,  4'b0000, 0, 1, 0, 0, 4'b1000, 0, 0, "fill1");
    step(SHR,  4'b0000, 0, 1, 0, 0, 4'b1100, 0, 0, "fill2");
    step(SHR,  4'b0000, 0, 0, 0, 0, 4'b0110, 0, 0, "fill3");
    step(SHR,  4'b0000, 0, 1, 0, 0, 4'b1011, 0, 0, "fill4");
    step(3'd6, 4'b1111, 1, 1, 0, 0, 4'b1011, 0, 0, "code6");
    step(3'd7, 4'b1111, 1, 1, 0, 0, 4'b1011, 0, 0, "code7");
    step(HOLD, 4'b1111, 1, 1, 0, 0, 4'b1011, 0, 0, "hold");
    step(ROTR, 4'b0000, 0, 0, 0, 0, 4'b1101, 0, 0, "rotr");
    step(ROTL, 4'b0000, 0, 0, 0, 0, 4'b1011, 0, 0, "rotl");

    // Degenerate bursts
    step(SHL,  4'b0000, 1, 0, 1, 4'd0, 4'b1011, 1, 1, "cnt0 start");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b1011, 0, 0, "cnt0 idle");
    step(LOAD, 4'b0000, 0, 0, 1, 4'd5, 4'b1011, 1, 1, "load5 start");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b1011, 0, 0, "load5 idle");

    // Burst rotate, count 3, mode/D changes during RUN ignored
    step(LOAD, 4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0, "rot preload");
    step(ROTL, 4'b0000, 0, 0, 1, 4'd3, 4'b1000, 1, 0, "rot start");
    step(SHR,  4'b1111, 1, 1, 0, 4'd9, 4'b0001, 1, 0, "rot op1");
    step(LOAD, 4'b1111, 1, 1, 0, 4'd9, 4'b0010, 1, 0, "rot op2");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0100, 1, 1, "rot fin");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0100, 0, 0, "rot idle");

    // Start held high across a count-2 burst
    step(ROTR, 4'b0000, 0, 0, 1, 4'd2, 4'b0100, 1, 0, "hs start");
    step(SHL,  4'b1111, 1, 1, 1, 4'd2, 4'b0010, 1, 0, "hs op1");
    step(SHL,  4'b1111, 1, 1, 1, 4'd2, 4'b0001, 1, 1, "hs fin");
    step(ROTR, 4'b0000, 0, 0, 1, 4'd2, 4'b0001, 0, 0, "hs start in fin");
    step(ROTR, 4'b0000, 0, 0, 1, 4'd2, 4'b0001, 1, 0, "hs restart");
    step(ROTR, 4'b0000, 0, 0, 0, 4'd2, 4'b1000, 1, 0, "hs2 op1");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0100, 1, 1, "hs2 fin");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0100, 0, 0, "hs2 idle");

    // Burst SHL sampling Sin_L live
    step(SHL,  4'b0000, 0, 0, 1, 4'd2, 4'b0100, 1, 0, "live start");
    step(HOLD, 4'b0000, 1, 0, 0, 4'd0, 4'b1001, 1, 0, "live op1");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0010, 1, 1, "live fin");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0010, 0, 0, "live idle");

    // Maximum count 15
    step(LOAD, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, 0, "max preload");
    step(ROTL, 4'b0000, 0, 0, 1, 4'd15, 4'b0001, 1, 0, "max start");
    for (int k = 1; k <= 15; k++)
      step(HOLD, 4'b0000, 0, 0, 0, 4'd0, rotl_pat[k % 4], 1'b1, (k == 15), $sformatf("max op%0d", k));
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b1000, 0, 0, "max idle");

    // Reset in the middle of a burst
    step(LOAD, 4'b1111, 0, 0, 0, 0, 4'b1111, 0, 0, "rst preload");
    step(SHR,  4'b0000, 0, 0, 1, 4'd10, 4'b1111, 1, 0, "rst start");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0111, 1, 0, "rst op1");
    step(HOLD, 4'b0000, 0, 0, 0, 4'd0, 4'b0011, 1, 0, "rst op2");
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst Q", Q, 4'b0000);
    check("midrst Busy", {3'b0, Busy}, 4'b0000);
    check("midrst Done", {3'b0, Done}, 4'b0000);
    @(negedge Clk); Rst_n = 1'b1;
    drive(LOAD, 4'b0101, 0, 0, 0, 0, 4'b0101, 0, 0, "post rst load");
    step(HOLD, 4'b0000, 0, 0, 0, 0, 4'b0101, 0, 0, "post rst hold");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
